// File: rtl/nfu_2_accum_if.sv
// Bundle of NFU-2 signals: the tagged product beat from NFU-1 and the
// neuron-sum result and status that go on to NFU-3.
interface nfu_2_accum_if #(
    parameter int BIT_WIDTH = 16,
    parameter int Tn        = 16
);
    logic [Tn*Tn*BIT_WIDTH-1:0] i_nfu1_out;
    logic                       i_valid;
    logic                       i_first;
    logic                       i_last;
    logic [Tn*BIT_WIDTH-1:0]    o_nfu2_out;
    logic                       o_valid;
    logic                       o_busy;
    logic                       o_seq_err;

    modport master (
        output i_nfu1_out, i_valid, i_first, i_last,
        input  o_nfu2_out, o_valid, o_busy, o_seq_err
    );

    modport slave (
        input  i_nfu1_out, i_valid, i_first, i_last,
        output o_nfu2_out, o_valid, o_busy, o_seq_err
    );
endinterface

// File: rtl/nfu_2_accum.sv
// NFU-2: per-neuron pipelined saturating adder tree followed by an
// accumulator that sums tree results across a first..last framed group.
//
// state   | meaning
// S_IDLE  | no group open; the next tree beat starts a new group
// S_ACCUM | group open; tree beats are added into the accumulators
module nfu_2_accum #(
    parameter int BIT_WIDTH = 16,
    parameter int Q         = 10,
    parameter int Tn        = 16,
    parameter int LOG2_TN   = 4
) (
    input  logic           clk,
    input  logic           rst,
    nfu_2_accum_if.slave   bus
);

    if (Tn != (1 << LOG2_TN)) begin : g_bad_tn
        $error("nfu_2_accum: Tn must equal 2**LOG2_TN");
    end
    if (Q >= BIT_WIDTH) begin : g_bad_q
        $error("nfu_2_accum: Q must be smaller than BIT_WIDTH");
    end

    localparam logic [BIT_WIDTH-1:0] SAT_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic [BIT_WIDTH-1:0] SAT_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};

    typedef enum logic {S_IDLE, S_ACCUM} state_e;

    function automatic logic [BIT_WIDTH-1:0] sat_add(input logic [BIT_WIDTH-1:0] a,
                                                     input logic [BIT_WIDTH-1:0] b);
        logic [BIT_WIDTH:0] s;
        s = {a[BIT_WIDTH-1], a} + {b[BIT_WIDTH-1], b};
        if (s[BIT_WIDTH] != s[BIT_WIDTH-1]) return s[BIT_WIDTH] ? SAT_MIN : SAT_MAX;
        return s[BIT_WIDTH-1:0];
    endfunction

    // Heap layout per neuron: node i has children 2i and 2i+1; indices Tn..2Tn-1
    // are the raw products, 1..Tn-1 are tree registers, node 1 is the root.
    logic [BIT_WIDTH-1:0] kid    [Tn][2*Tn];
    logic [BIT_WIDTH-1:0] node_q [Tn][1:Tn-1];
    logic [LOG2_TN:1]     v_q, f_q, l_q;

    state_e               state_q, state_d;
    logic [BIT_WIDTH-1:0] acc_q [Tn];
    logic [BIT_WIDTH-1:0] acc_d [Tn];
    logic [BIT_WIDTH-1:0] out_q [Tn];
    logic [BIT_WIDTH-1:0] out_d [Tn];
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 restart;

    always_comb begin
        for (int n = 0; n < Tn; n++) begin
            kid[n][0] = '0;
            for (int i = 1; i < Tn; i++) kid[n][i] = node_q[n][i];
            for (int k = 0; k < Tn; k++)
                kid[n][Tn+k] = bus.i_nfu1_out[(n*Tn+k)*BIT_WIDTH +: BIT_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < Tn; n++)
            for (int i = 1; i < Tn; i++)
                node_q[n][i] <= sat_add(kid[n][2*i], kid[n][2*i+1]);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        out_d   = out_q;
        valid_d = 1'b0;
        err_d   = err_q;
        restart = 1'b0;
        if (v_q[LOG2_TN]) begin
            restart = f_q[LOG2_TN] || (state_q == S_IDLE);
            if (!f_q[LOG2_TN] && (state_q == S_IDLE)) err_d = 1'b1;
            if (f_q[LOG2_TN] && (state_q == S_ACCUM)) err_d = 1'b1;
            for (int n = 0; n < Tn; n++)
                acc_d[n] = restart ? node_q[n][1] : sat_add(acc_q[n], node_q[n][1]);
            if (l_q[LOG2_TN]) begin
                out_d   = acc_d;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end else begin
                state_d = S_ACCUM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q     <= '0;
            f_q     <= '0;
            l_q     <= '0;
            state_q <= S_IDLE;
            acc_q   <= '{default: '0};
            out_q   <= '{default: '0};
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            v_q[1] <= bus.i_valid;
            f_q[1] <= bus.i_valid & bus.i_first;
            l_q[1] <= bus.i_valid & bus.i_last;
            for (int l = 2; l <= LOG2_TN; l++) begin
                v_q[l] <= v_q[l-1];
                f_q[l] <= f_q[l-1];
                l_q[l] <= l_q[l-1];
            end
            state_q <= state_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    for (genvar gn = 0; gn < Tn; gn++) begin : g_out
        assign bus.o_nfu2_out[gn*BIT_WIDTH +: BIT_WIDTH] = out_q[gn];
    end

    assign bus.o_valid   = valid_q;
    assign bus.o_busy    = (|v_q) || (state_q == S_ACCUM);
    assign bus.o_seq_err = err_q;

endmodule

// File: tb/tb_nfu_2_accum.sv
// Bench for nfu_2_accum: directed and random groups scored against a
// reference that reduces each neuron's products and accumulates by group.
module tb_nfu_2_accum;
    localparam int BW  = 16;
    localparam int TN  = 16;
    localparam int LAT = 5;

    typedef logic [TN*TN*BW-1:0] beat_t;
    typedef logic [TN*BW-1:0]    out_t;
    typedef struct {int cyc; out_t data;} ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    nfu_2_accum_if #(.BIT_WIDTH(BW), .Tn(TN)) bus();
    nfu_2_accum #(.BIT_WIDTH(BW), .Q(10), .Tn(TN), .LOG2_TN(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  checks = 0;
    int  failures = 0;

    bit  m_active;
    bit  m_err;
    int  m_acc[TN];

    always @(negedge clk) if (!rst && bus.o_valid) obs_q.push_back('{cyc, bus.o_nfu2_out});

    function automatic int sat(input int a, input int b);
        int s = a + b;
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    function automatic int neuron_tree(input beat_t b, input int n);
        int v[TN];
        int w;
        for (int k = 0; k < TN; k++) v[k] = int'($signed(b[(n*TN+k)*BW +: BW]));
        w = TN;
        while (w > 1) begin
            for (int i = 0; i < w/2; i++) v[i] = sat(v[2*i], v[2*i+1]);
            w = w / 2;
        end
        return v[0];
    endfunction

    function automatic beat_t fill(input logic [BW-1:0] val);
        beat_t b;
        for (int i = 0; i < TN*TN; i++) b[i*BW +: BW] = val;
        return b;
    endfunction

    function automatic beat_t rand_beat(input int mode);
        beat_t b;
        for (int i = 0; i < TN*TN; i++)
            b[i*BW +: BW] = (mode == 0) ? BW'($urandom_range(0, 1023) - 512) : BW'($urandom);
        return b;
    endfunction

    function automatic void model_beat(input beat_t b, input bit f, input bit l, input int t);
        out_t o;
        for (int n = 0; n < TN; n++) begin
            int ts = neuron_tree(b, n);
            m_acc[n] = (f || !m_active) ? ts : sat(m_acc[n], ts);
            o[n*BW +: BW] = BW'(m_acc[n]);
        end
        if (f == m_active) m_err = 1'b1;
        if (l) begin
            exp_q.push_back('{t + LAT, o});
            m_active = 1'b0;
        end else begin
            m_active = 1'b1;
        end
    endfunction

    task automatic drive(input beat_t b, input bit f, input bit l);
        @(negedge clk);
        bus.i_nfu1_out = b;
        bus.i_valid    = 1'b1;
        bus.i_first    = f;
        bus.i_last     = l;
        model_beat(b, f, l, cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            bus.i_first = 1'b0;
            bus.i_last  = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_first = 1'b0;
        bus.i_last  = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        obs_q.delete();
        m_active = 1'b0;
        m_err    = 1'b0;
        for (int n = 0; n < TN; n++) m_acc[n] = 0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        idle(2);
        checks++;
        if (bus.o_nfu2_out !== '0 || bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_seq_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state out=%h valid=%b busy=%b err=%b expected all zero",
                     bus.o_nfu2_out, bus.o_valid, bus.o_busy, bus.o_seq_err);
        end
    endtask

    task automatic test_single();
        drive(fill(16'h0400), 1'b1, 1'b1);
        idle(LAT + 3);
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            failures++;
            $display("FAIL single_count got=%0d expected=1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].cyc !== exp_q[0].cyc || obs_q[0].data !== {TN{16'h4000}}) begin
                failures++;
                $display("FAIL single_sum cyc=%0d data=%h expected cyc=%0d data all 4000",
                         obs_q[0].cyc, obs_q[0].data, exp_q[0].cyc);
            end
        end
        checks++;
        if (bus.o_seq_err !== 1'b0 || bus.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL single_status err=%b busy=%b expected 0 0", bus.o_seq_err, bus.o_busy);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_multi_beat();
        drive(fill(16'h0040), 1'b1, 1'b0);
        drive(fill(16'h0040), 1'b0, 1'b0);
        drive(fill(16'h0040), 1'b0, 1'b1);
        idle(LAT + 3);
        checks++;
        if (obs_q.size() != 1) begin
            failures++;
            $display("FAIL multi_count got=%0d expected=1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].cyc !== exp_q[0].cyc || obs_q[0].data !== {TN{16'h0C00}}) begin
                failures++;
                $display("FAIL multi_sum cyc=%0d data=%h expected cyc=%0d data all 0C00",
                         obs_q[0].cyc, obs_q[0].data, exp_q[0].cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_saturation();
        beat_t mixed;
        for (int i = 0; i < TN*TN; i++) mixed[i*BW +: BW] = (i % 2 == 0) ? 16'h0400 : 16'hFC00;
        drive(fill(16'h7000), 1'b1, 1'b1);
        drive(fill(16'h9000), 1'b1, 1'b1);
        drive(mixed, 1'b1, 1'b1);
        drive(fill(16'h2000), 1'b1, 1'b0);
        drive(fill(16'h2000), 1'b0, 1'b1);
        idle(LAT + 3);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL sat_count got=%0d expected=%0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].data !== exp_q[i].data) begin
                    failures++;
                    $display("FAIL sat_ev%0d cyc=%0d data=%h expected cyc=%0d data=%h",
                             i, obs_q[i].cyc, obs_q[i].data, exp_q[i].cyc, exp_q[i].data);
                end
            end
            checks++;
            if (obs_q[0].data !== {TN{16'h7FFF}} || obs_q[1].data !== {TN{16'h8000}} || obs_q[2].data !== '0) begin
                failures++;
                $display("FAIL sat_const pos=%h neg=%h mix=%h expected 7FFF 8000 0000",
                         obs_q[0].data[15:0], obs_q[1].data[15:0], obs_q[2].data[15:0]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        drive(fill(16'h0400), 1'b1, 1'b1);
        drive(fill(16'h0200), 1'b1, 1'b0);
        drive(fill(16'h0200), 1'b0, 1'b1);
        idle(LAT + 3);
        checks++;
        if (obs_q.size() != 2) begin
            failures++;
            $display("FAIL b2b_count got=%0d expected=2", obs_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].data !== {TN{16'h4000}}) begin
                    failures++;
                    $display("FAIL b2b_ev%0d cyc=%0d data=%h expected cyc=%0d data all 4000",
                             i, obs_q[i].cyc, obs_q[i].data, exp_q[i].cyc);
                end
            end
        end
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_seq_err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_status busy=%b err=%b expected 0 0", bus.o_busy, bus.o_seq_err);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_framing();
        drive(fill(16'h0100), 1'b0, 1'b0);
        drive(fill(16'h0100), 1'b0, 1'b1);
        idle(2);
        drive(fill(16'h0300), 1'b1, 1'b0);
        drive(fill(16'h0080), 1'b1, 1'b0);
        drive(fill(16'h0080), 1'b0, 1'b1);
        idle(LAT + 3);
        checks++;
        if (obs_q.size() != exp_q.size() || obs_q.size() != 2) begin
            failures++;
            $display("FAIL frame_count got=%0d expected=2", obs_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].data !== exp_q[i].data) begin
                    failures++;
                    $display("FAIL frame_ev%0d cyc=%0d data=%h expected cyc=%0d data=%h",
                             i, obs_q[i].cyc, obs_q[i].data, exp_q[i].cyc, exp_q[i].data);
                end
            end
            checks++;
            if (obs_q[1].data !== {TN{16'h1000}}) begin
                failures++;
                $display("FAIL frame_restart got=%h expected all 1000", obs_q[1].data);
            end
        end
        idle(4);
        checks++;
        if (bus.o_seq_err !== m_err || bus.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL frame_status err=%b busy=%b expected err=%b busy=0", bus.o_seq_err, bus.o_busy, m_err);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_inflight();
        drive(fill(16'h0400), 1'b1, 1'b0);
        drive(fill(16'h0400), 1'b0, 1'b0);
        drive(fill(16'h0400), 1'b0, 1'b1);
        do_reset();
        idle(LAT + 5);
        checks++;
        if (obs_q.size() != 0 || bus.o_nfu2_out !== '0 || bus.o_busy !== 1'b0 || bus.o_seq_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_flush events=%0d out=%h busy=%b err=%b expected 0 0 0 0",
                     obs_q.size(), bus.o_nfu2_out, bus.o_busy, bus.o_seq_err);
        end
        drive(fill(16'h0200), 1'b1, 1'b0);
        drive(fill(16'h0100), 1'b0, 1'b1);
        idle(LAT + 3);
        checks++;
        if (obs_q.size() != 1) begin
            failures++;
            $display("FAIL rst_fresh_count got=%0d expected=1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].cyc !== exp_q[0].cyc || obs_q[0].data !== {TN{16'h3000}}) begin
                failures++;
                $display("FAIL rst_fresh_sum cyc=%0d data=%h expected cyc=%0d data all 3000",
                         obs_q[0].cyc, obs_q[0].data, exp_q[0].cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random();
        for (int g = 0; g < 12; g++) begin
            int nb   = $urandom_range(1, 4);
            int mode = $urandom_range(0, 1);
            for (int b = 0; b < nb; b++) begin
                bit f = (b == 0) || ($urandom_range(0, 9) == 0);
                drive(rand_beat(mode), f, b == nb - 1);
            end
            idle($urandom_range(0, 2));
        end
        idle(LAT + 3);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rand_count got=%0d expected=%0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].data !== exp_q[i].data) begin
                    failures++;
                    $display("FAIL rand_ev%0d cyc=%0d data=%h expected cyc=%0d data=%h",
                             i, obs_q[i].cyc, obs_q[i].data, exp_q[i].cyc, exp_q[i].data);
                end
            end
        end
        checks++;
        if (bus.o_seq_err !== m_err || bus.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL rand_status err=%b busy=%b expected err=%b busy=0", bus.o_seq_err, bus.o_busy, m_err);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        bus.i_nfu1_out = '0;
        bus.i_valid    = 1'b0;
        bus.i_first    = 1'b0;
        bus.i_last     = 1'b0;
        test_reset();
        test_single();
        test_multi_beat();
        test_saturation();
        test_back_to_back();
        test_framing();
        test_reset_inflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
